// File: rtl/jtag_bsr_ctrl.sv
// jtag_bsr_ctrl: parametrised boundary-scan data register (TCK domain).
// Chain LSB-first: [IN | OUT | OE | COMMIT]; one update latch pair shared by
// SAMPLE/PRELOAD and EXTEST; CLAMP/HIGHZ pad overrides; functional/test pad mux.
// Optional macro JTAG_BSR_LENCHK_EN: adds a shift counter so updates are only
// accepted after exactly BSR_LEN shifts, with a sticky len_err_o otherwise.
module jtag_bsr_ctrl #(
   parameter int unsigned N_GPIO = 14,
   parameter int unsigned N_DIN  = 14
) (
   input  logic                      tck_i,
   input  logic                      test_logic_reset_i,
   input  logic                      capture_dr_i,
   input  logic                      shift_dr_i,
   input  logic                      update_dr_i,
   input  logic                      extest_select_i,
   input  logic                      sample_preload_select_i,
   input  logic                      clamp_select_i,
   input  logic                      highz_select_i,
   input  logic                      tdi_i,
   output logic                      tdo_o,
   input  logic [N_GPIO+N_DIN-1:0]   bsr_i,
   input  logic [N_GPIO-1:0]         func_o_i,
   input  logic [N_GPIO-1:0]         func_oe_i,
   output logic [N_GPIO-1:0]         bsr_o,
   output logic [N_GPIO-1:0]         bsr_oe,
   output logic                      override_o,
   output logic                      len_err_o
);

   localparam int unsigned IN_LEN     = N_GPIO + N_DIN;
   localparam int unsigned OUT_LEN    = N_GPIO;
   localparam int unsigned OE_LEN     = N_GPIO;
   localparam int unsigned BSR_LEN    = IN_LEN + OUT_LEN + OE_LEN + 1;
   localparam int unsigned OUT_LSB    = IN_LEN;
   localparam int unsigned OE_LSB     = IN_LEN + OUT_LEN;
   localparam int unsigned COMMIT_BIT = BSR_LEN - 1;

   logic [BSR_LEN-1:0] shift_q;
   logic [OUT_LEN-1:0] upd_out_q;
   logic [OE_LEN-1:0]  upd_oe_q;
   logic               dr_active_c;
   logic               do_capture_c;
   logic               do_shift_c;
   logic               do_update_c;
   logic               commit_c;
   logic               len_ok_c;

   // Strobe qualification with capture > shift > update priority
   always_comb begin
      dr_active_c  = extest_select_i | sample_preload_select_i;
      do_capture_c = dr_active_c & capture_dr_i;
      do_shift_c   = dr_active_c & shift_dr_i & ~capture_dr_i;
      do_update_c  = dr_active_c & update_dr_i & ~capture_dr_i & ~shift_dr_i;
      commit_c     = shift_q[COMMIT_BIT];
   end

   // Capture/shift stage; COMMIT captures as 0 so a stale commit never re-applies
   always_ff @(posedge tck_i or posedge test_logic_reset_i) begin
      if (test_logic_reset_i) begin
         shift_q <= '0;
      end else if (do_capture_c) begin
         shift_q <= {1'b0, upd_oe_q, upd_out_q, bsr_i};
      end else if (do_shift_c) begin
         shift_q <= {tdi_i, shift_q[BSR_LEN-1:1]};
      end
   end

`ifdef JTAG_BSR_LENCHK_EN
   localparam int unsigned CNT_W = $clog2(BSR_LEN + 2);

   logic [CNT_W-1:0] cnt_q;
   logic             len_err_q;

   assign len_ok_c  = (cnt_q == CNT_W'(BSR_LEN));
   assign len_err_o = len_err_q;

   // Shift counter saturating at BSR_LEN+1 so over-length scans stay detectable
   always_ff @(posedge tck_i or posedge test_logic_reset_i) begin
      if (test_logic_reset_i) begin
         cnt_q <= '0;
      end else if (do_capture_c) begin
         cnt_q <= '0;
      end else if (do_shift_c && (cnt_q != CNT_W'(BSR_LEN + 1))) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Sticky length error: set by a committed update of the wrong length, cleared on capture
   always_ff @(posedge tck_i or posedge test_logic_reset_i) begin
      if (test_logic_reset_i) begin
         len_err_q <= 1'b0;
      end else if (do_capture_c) begin
         len_err_q <= 1'b0;
      end else if (do_update_c && commit_c && !len_ok_c) begin
         len_err_q <= 1'b1;
      end
   end
`else
   assign len_ok_c  = 1'b1;
   assign len_err_o = 1'b0;
`endif

   // Update stage; latches survive instruction changes so PRELOAD feeds EXTEST
   always_ff @(posedge tck_i or posedge test_logic_reset_i) begin
      if (test_logic_reset_i) begin
         upd_out_q <= '0;
         upd_oe_q  <= '0;
      end else if (do_update_c && commit_c && len_ok_c) begin
         upd_out_q <= shift_q[OUT_LSB +: OUT_LEN];
         upd_oe_q  <= shift_q[OE_LSB  +: OE_LEN];
      end
   end

   // Pad mux and serial out: HIGHZ over EXTEST/CLAMP over functional
   always_comb begin
      bsr_o      = func_o_i;
      bsr_oe     = func_oe_i;
      override_o = extest_select_i | clamp_select_i | highz_select_i;
      tdo_o      = dr_active_c ? shift_q[0] : 1'b0;
      if (highz_select_i) begin
         bsr_o  = '0;
         bsr_oe = '0;
      end else if (extest_select_i || clamp_select_i) begin
         bsr_o  = upd_out_q;
         bsr_oe = upd_oe_q;
      end
   end

endmodule

// File: tb/tb_jtag_bsr_ctrl.sv
// tb_jtag_bsr_ctrl: directed bench for jtag_bsr_ctrl at default sizes (BSR_LEN=57).
module tb_jtag_bsr_ctrl;

   logic        tck;
   logic        rst;
   logic        capture, shift, update;
   logic        sel_ext, sel_sp, sel_clamp, sel_hz;
   logic        tdi, tdo;
   logic [27:0] bsr_in;
   logic [13:0] func_o, func_oe;
   logic [13:0] bsr_o, bsr_oe;
   logic        override, len_err;

   int n_cmp = 0;
   int n_err = 0;

   // Bench-side view of the update latches and sticky error
   logic [13:0] exp_out = '0;
   logic [13:0] exp_oe  = '0;
   logic        exp_err = 1'b0;

   jtag_bsr_ctrl dut (
      .tck_i                   (tck),
      .test_logic_reset_i      (rst),
      .capture_dr_i            (capture),
      .shift_dr_i              (shift),
      .update_dr_i             (update),
      .extest_select_i         (sel_ext),
      .sample_preload_select_i (sel_sp),
      .clamp_select_i          (sel_clamp),
      .highz_select_i          (sel_hz),
      .tdi_i                   (tdi),
      .tdo_o                   (tdo),
      .bsr_i                   (bsr_in),
      .func_o_i                (func_o),
      .func_oe_i               (func_oe),
      .bsr_o                   (bsr_o),
      .bsr_oe                  (bsr_oe),
      .override_o              (override),
      .len_err_o               (len_err)
   );

   initial tck = 1'b0;
   always #5 tck = ~tck;

   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   function automatic logic [63:0] frame(input logic [27:0] fin, input logic [13:0] fout,
                                         input logic [13:0] foe, input logic fcommit);
      logic [63:0] f;
      f = '0;
      f[56:0] = {fcommit, foe, fout, fin};
      return f;
   endfunction

   // Shift register contents after n shifts of v on top of captured c
   function automatic logic [56:0] model_sr(input logic [56:0] c, input logic [63:0] v, input int n);
      logic [56:0] r;
      for (int k = 0; k < 57; k++) begin
         if (k + n - 57 >= 0) r[k] = v[k + n - 57];
         else                 r[k] = c[k + n];
      end
      return r;
   endfunction

   // Capture, n shifts of vec (tdo recorded per bit), update; advances the expected latches
   task automatic scan(input logic [63:0] vec, input int n, output logic [63:0] obs);
      logic [56:0] cap;
      logic [56:0] sr;
      cap = {1'b0, exp_oe, exp_out, bsr_in};
      obs = '0;
      capture = 1'b1; tick(); capture = 1'b0;
      exp_err = 1'b0;
      shift = 1'b1;
      for (int i = 0; i < n; i++) begin
         tdi = vec[i];
         obs[i] = tdo;
         tick();
      end
      shift = 1'b0; tdi = 1'b0;
      update = 1'b1; tick(); update = 1'b0;
      sr = model_sr(cap, vec, n);
      if (sr[56]) begin
`ifdef JTAG_BSR_LENCHK_EN
         if (n == 57) begin
            exp_out = sr[41:28];
            exp_oe  = sr[55:42];
         end else begin
            exp_err = 1'b1;
         end
`else
         exp_out = sr[41:28];
         exp_oe  = sr[55:42];
`endif
      end
   endtask

   task automatic test_reset();
      n_cmp++; if (tdo !== 1'b0) begin n_err++; $display("FAIL reset_tdo got %b want 0", tdo); end
      n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL reset_len_err got %b want 0", len_err); end
      n_cmp++; if (bsr_o !== 14'h0 || bsr_oe !== 14'h0) begin n_err++; $display("FAIL reset_pads got %h/%h want 0/0", bsr_o, bsr_oe); end
      n_cmp++; if (override !== 1'b0) begin n_err++; $display("FAIL reset_override got %b want 0", override); end
   endtask

   task automatic test_sample();
      logic [63:0] obs;
      logic        want;
      sel_sp = 1'b1; func_o = 14'h1234; func_oe = 14'h0F0F; bsr_in = 28'h0ABCDEF;
      tick();
      scan(64'h0, 57, obs);
      for (int i = 0; i < 57; i++) begin
         want = (i < 28) ? bsr_in[i] : 1'b0;
         n_cmp++;
         if (obs[i] !== want) begin n_err++; $display("FAIL sample_tdo bit %0d got %b want %b", i, obs[i], want); end
      end
      n_cmp++; if (bsr_o !== 14'h1234 || bsr_oe !== 14'h0F0F) begin n_err++; $display("FAIL sample_func_pads got %h/%h want 1234/0f0f", bsr_o, bsr_oe); end
      n_cmp++; if (override !== 1'b0) begin n_err++; $display("FAIL sample_override got %b want 0", override); end
   endtask

   task automatic test_preload_extest();
      logic [63:0] obs;
      scan(frame(28'h0, 14'h2AAA, 14'h3FFF, 1'b1), 57, obs);
      n_cmp++; if (bsr_o !== 14'h1234) begin n_err++; $display("FAIL preload_still_func got %h want 1234", bsr_o); end
      sel_sp = 1'b0; sel_ext = 1'b1;
      tick();
      n_cmp++; if (bsr_o !== 14'h2AAA || bsr_oe !== 14'h3FFF) begin n_err++; $display("FAIL extest_pads got %h/%h want 2aaa/3fff", bsr_o, bsr_oe); end
      n_cmp++; if (override !== 1'b1) begin n_err++; $display("FAIL extest_override got %b want 1", override); end
      n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL preload_len_err got %b want 0", len_err); end
   endtask

   task automatic test_commit0();
      logic [63:0] obs;
      scan(frame(28'h0, 14'h1555, 14'h0000, 1'b0), 57, obs);
      n_cmp++; if (obs[41:28] !== 14'h2AAA) begin n_err++; $display("FAIL commit0_capture_out got %h want 2aaa", obs[41:28]); end
      n_cmp++; if (bsr_o !== 14'h2AAA || bsr_oe !== 14'h3FFF) begin n_err++; $display("FAIL commit0_latches got %h/%h want 2aaa/3fff", bsr_o, bsr_oe); end
      n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL commit0_len_err got %b want 0", len_err); end
   endtask

   task automatic test_len_err();
      logic [63:0] obs;
      logic [63:0] v;
      v = frame(28'h0, 14'h0F0F, 14'h3C3C, 1'b0);
      v[55] = 1'b1;
      scan(v, 56, obs);
`ifdef JTAG_BSR_LENCHK_EN
      n_cmp++; if (bsr_o !== 14'h2AAA) begin n_err++; $display("FAIL short_latch got %h want 2aaa", bsr_o); end
      n_cmp++; if (len_err !== 1'b1) begin n_err++; $display("FAIL short_len_err got %b want 1", len_err); end
`else
      n_cmp++; if (bsr_o !== 14'h1E1E || bsr_oe !== 14'h3878) begin n_err++; $display("FAIL short_latch got %h/%h want 1e1e/3878", bsr_o, bsr_oe); end
      n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL short_len_err got %b want 0", len_err); end
`endif
      capture = 1'b1; tick(); capture = 1'b0; exp_err = 1'b0;
      n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL short_clear got %b want 0", len_err); end

      v = frame(28'h0, 14'h0F0F, 14'h3C3C, 1'b1);
      v[57] = 1'b1;
      scan(v, 58, obs);
      n_cmp++; if (bsr_o !== exp_out || bsr_oe !== exp_oe) begin n_err++; $display("FAIL long_latch got %h/%h want %h/%h", bsr_o, bsr_oe, exp_out, exp_oe); end
`ifndef JTAG_BSR_LENCHK_EN
      n_cmp++; if (bsr_o !== 14'h0787) begin n_err++; $display("FAIL long_update got %h want 0787", bsr_o); end
`endif
      n_cmp++; if (len_err !== exp_err) begin n_err++; $display("FAIL long_len_err got %b want %b", len_err, exp_err); end
      capture = 1'b1; tick(); capture = 1'b0; exp_err = 1'b0;
      n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL long_clear got %b want 0", len_err); end
   endtask

   task automatic test_clamp_highz();
      logic [63:0] obs;
      bsr_in = 28'hFFFFFFF;
      scan(frame(28'hFFFFFFF, 14'h00FF, 14'h3FFF, 1'b1), 57, obs);
      n_cmp++; if (bsr_o !== 14'h00FF || bsr_oe !== 14'h3FFF) begin n_err++; $display("FAIL extest_ff got %h/%h want 00ff/3fff", bsr_o, bsr_oe); end
      sel_ext = 1'b0; sel_clamp = 1'b1;
      tick();
      n_cmp++; if (bsr_o !== 14'h00FF || bsr_oe !== 14'h3FFF) begin n_err++; $display("FAIL clamp_pads got %h/%h want 00ff/3fff", bsr_o, bsr_oe); end
      n_cmp++; if (tdo !== 1'b0) begin n_err++; $display("FAIL clamp_tdo got %b want 0", tdo); end
      n_cmp++; if (override !== 1'b1) begin n_err++; $display("FAIL clamp_override got %b want 1", override); end
      // Strobes under CLAMP must not touch this register
      capture = 1'b1; tick(); capture = 1'b0;
      update = 1'b1; tick(); update = 1'b0;
      n_cmp++; if (bsr_o !== 14'h00FF) begin n_err++; $display("FAIL clamp_strobes got %h want 00ff", bsr_o); end
      sel_clamp = 1'b0; sel_hz = 1'b1;
      tick();
      n_cmp++; if (bsr_o !== 14'h0 || bsr_oe !== 14'h0) begin n_err++; $display("FAIL highz_pads got %h/%h want 0/0", bsr_o, bsr_oe); end
      n_cmp++; if (override !== 1'b1) begin n_err++; $display("FAIL highz_override got %b want 1", override); end
      sel_hz = 1'b0;
      tick();
      n_cmp++; if (bsr_o !== 14'h1234 || override !== 1'b0) begin n_err++; $display("FAIL func_return got %h/%b want 1234/0", bsr_o, override); end
   endtask

   task automatic test_reset_mid_scan();
      sel_ext = 1'b1; bsr_in = 28'h0;
      capture = 1'b1; tick(); capture = 1'b0;
      shift = 1'b1; tdi = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      rst = 1'b1; sel_ext = 1'b0; func_o = 14'h0; func_oe = 14'h0;
      #1;
      n_cmp++; if (tdo !== 1'b0 || len_err !== 1'b0) begin n_err++; $display("FAIL midrst_tdo_err got %b/%b want 0/0", tdo, len_err); end
      n_cmp++; if (bsr_o !== 14'h0 || bsr_oe !== 14'h0) begin n_err++; $display("FAIL midrst_pads got %h/%h want 0/0", bsr_o, bsr_oe); end
      tick();
      shift = 1'b0; tdi = 1'b0;
      tick();
      rst = 1'b0; exp_out = '0; exp_oe = '0;
      sel_sp = 1'b1;
      tick();
      n_cmp++; if (tdo !== 1'b0) begin n_err++; $display("FAIL midrst_shift_cleared got %b want 0", tdo); end
      sel_sp = 1'b0; sel_ext = 1'b1;
      tick();
      n_cmp++; if (bsr_o !== 14'h0 || bsr_oe !== 14'h0) begin n_err++; $display("FAIL midrst_latches got %h/%h want 0/0", bsr_o, bsr_oe); end
      sel_ext = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      capture = 1'b0; shift = 1'b0; update = 1'b0;
      sel_ext = 1'b0; sel_sp = 1'b0; sel_clamp = 1'b0; sel_hz = 1'b0;
      tdi = 1'b0; bsr_in = '0; func_o = '0; func_oe = '0;
      tick(); tick();
      test_reset();
      rst = 1'b0;
      tick();
      test_sample();
      test_preload_extest();
      test_commit0();
      test_len_err();
      test_clamp_highz();
      test_reset_mid_scan();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/jtag_bsr_ctrl.md
Name: jtag_bsr_ctrl

Overview:
- Parametrised boundary-scan data register for the JTAG test interface, in the TCK domain.
- Supports any GPIO/DIN pad count and a two-stage shift/update structure, with one update latch shared by SAMPLE/PRELOAD and EXTEST.
- Adds CLAMP and HIGHZ pad-override modes, a functional/test pad mux, and a shift-length check that rejects malformed scans.
- Sits between the TAP controller / instruction decoder and the pad ring.

Parameters:
- N_GPIO, 14, bidirectional pads with IN/OUT/OE cells.
- N_DIN, 14, input-only pads with IN cells.
- Derived, not overridable:
  - IN_LEN = N_GPIO+N_DIN
  - OUT_LEN = OE_LEN = N_GPIO
  - BSR_LEN = IN_LEN+OUT_LEN+OE_LEN+1
  - CNT_W = $clog2(BSR_LEN+2)

Ports:
- tck_i  in  1  TCK
- test_logic_reset_i  in  1  reset, asynchronous, active-high
- capture_dr_i / shift_dr_i / update_dr_i  in  1 each  TAP state strobes
- extest_select_i / sample_preload_select_i / clamp_select_i / highz_select_i  in  1 each  decoded instruction, one-hot or all zero
- tdi_i  in  1  serial in
- tdo_o  out  1  serial out
- bsr_i  in  IN_LEN  pad input samples
- func_o_i  in  OUT_LEN  core functional output values
- func_oe_i  in  OE_LEN  core functional output enables
- bsr_o  out  OUT_LEN  to pad drivers
- bsr_oe  out  OE_LEN  to pad drivers
- override_o  out  1  pads under test control
- len_err_o  out  1  sticky shift-length error

Behaviour:
- Chain, LSB-first: [IN | OUT | OE | COMMIT].
  - IN: bits IN_LEN-1:0.
  - OUT: next OUT_LEN bits.
  - OE: next OE_LEN bits.
  - COMMIT: MSB.
- dr_active = extest_select_i | sample_preload_select_i. CLAMP and HIGHZ do not select this register; the external BYPASS register is used for them.
- Reset: the following are all 0 and held 0 while reset is asserted:
  - shift register
  - upd_out, upd_oe
  - shift counter
  - len_err_o
  - tdo_o
- Capture (dr_active & capture_dr_i, posedge TCK):
  - IN <= bsr_i, OUT <= upd_out, OE <= upd_oe, COMMIT <= 0.
  - Counter <= 0; len_err_o <= 0.
- Shift (dr_active & shift_dr_i):
  - shift <= {tdi_i, shift[BSR_LEN-1:1]}.
  - Counter increments and saturates at BSR_LEN+1.
- Update (dr_active & update_dr_i), evaluated on the pre-edge shift value:
  - COMMIT==1 and counter==BSR_LEN: upd_out <= OUT slice, upd_oe <= OE slice.
  - COMMIT==1 and counter!=BSR_LEN: latches unchanged; len_err_o <= 1.
  - COMMIT==0: no change, no error.
- Same-edge strobes: capture has priority over shift, and shift over update. The TAP never asserts these together, but the priority is defined anyway.
- Pause-DR: no strobe asserted, so all state is held.
- Update latches persist across instruction changes. PRELOAD followed by EXTEST drives the preloaded values immediately.
- Pad mux (combinational from registers and selects), priority top-down:
  - HIGHZ: bsr_o=0, bsr_oe=0.
  - EXTEST or CLAMP: bsr_o=upd_out, bsr_oe=upd_oe.
  - otherwise: bsr_o=func_o_i, bsr_oe=func_oe_i.
- override_o = extest_select_i | clamp_select_i | highz_select_i.
- tdo_o = dr_active ? shift[0] : 0.
- Reset mid-scan: all state clears. The TAP deasserts selects, so the pads return to functional.

Optional Feature:
- Macro JTAG_BSR_LENCHK_EN.
- Defined: shift counter and length check implemented as above; len_err_o as specified.
- Undefined: counter removed; update applies whenever COMMIT==1; len_err_o tied 0.

Test Plan:
- All tests use defaults, so BSR_LEN=57.
- Reset: assert reset mid-shift -> bsr_o=0, bsr_oe=0, tdo_o=0, len_err_o=0; shifted data discarded.
- SAMPLE/PRELOAD capture: bsr_i=28'h0ABCDEF, shift 57 bits of zero -> tdo_o emits 0x0ABCDEF LSB-first, followed by 29 zeros; bsr_o still follows func_o_i.
- PRELOAD then EXTEST:
  - Preload OUT=14'h2AAA, OE=14'h3FFF, COMMIT=1, exactly 57 shifts, update.
  - Switch to EXTEST -> bsr_o=14'h2AAA, bsr_oe=14'h3FFF on the next cycle with no further scan; override_o=1.
- COMMIT=0: shift 57 bits with OUT=14'h1555 and COMMIT=0, update -> latches unchanged, len_err_o=0.
- Length error: shift 56 bits and 58 bits (COMMIT=1 landing in MSB), each followed by update -> latches unchanged, len_err_o=1; the next capture clears it to 0.
  - With the macro undefined, the 58-bit case updates the latches and len_err_o stays 0.
- CLAMP/HIGHZ:
  - After EXTEST with OUT=14'h00FF, OE=14'h3FFF, select CLAMP -> pads hold 14'h00FF and tdo_o=0.
  - Select HIGHZ -> bsr_oe=0, bsr_o=0, override_o=1.
